q_table_reader: RTL and testbench

Read side of the Q-table BRAM interface in the Intellight accelerator. On `start`, the block addresses the four per-road Q-table BRAMs at state `S` and waits out the BRAM read latency. It then scans all `4*N_LEVEL` Q-values and returns the maximum (`Q_max`), its action (`A_max`) and the value of one requested action (`Q_sel`). The policy generator and the Q-update path use these results, and the update path writes back through the existing MII write path using the same address map.

---
 rtl/intellight_pkg.sv | 65 ++++++
 rtl/q_table_reader_if.sv | 49 ++++
 rtl/q_argmax_road.sv | 31 +++
 rtl/q_table_reader.sv | 221 ++++++++++++++++++++++
 tb/tb_q_table_reader.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/intellight_pkg.sv
// ----------------------------------------------------------------------------
// intellight_pkg
// Shared definitions for the Intellight Q-table access paths (read side and
// the MII write side).
//   - width helpers deriving every bus width from L_WIDTH / Q_WIDTH
//   - DEF_* constants: the widths of the default configuration
//   - bram_addr(): state -> BRAM byte address map, shared with the write path
//   - state_e: encodings of the Q-table reader FSM
// No ports (package).
// ----------------------------------------------------------------------------
package intellight_pkg;

    // Four roads, so the road part of an action is always 2 bits.
    localparam int N_ROAD       = 4;
    localparam int A_ROAD_WIDTH = 2;

    function automatic int n_level(input int l_width);
        return 1 << (l_width / 2);
    endfunction

    function automatic int s_width(input int l_width);
        return 2 * l_width;
    endfunction

    function automatic int a_dur_width(input int l_width);
        return l_width / 2;
    endfunction

    function automatic int a_width(input int l_width);
        return A_ROAD_WIDTH + a_dur_width(l_width);
    endfunction

    function automatic int d_width(input int q_width, input int l_width);
        return q_width * n_level(l_width);
    endfunction

    function automatic int wen_width(input int q_width, input int l_width);
        return d_width(q_width, l_width) / 8;
    endfunction

    // Widths of the default configuration (L_WIDTH=4, Q_WIDTH=16).
    localparam int DEF_L_WIDTH     = 4;
    localparam int DEF_Q_WIDTH     = 16;
    localparam int DEF_N_LEVEL     = n_level(DEF_L_WIDTH);
    localparam int DEF_S_WIDTH     = s_width(DEF_L_WIDTH);
    localparam int DEF_D_WIDTH     = d_width(DEF_Q_WIDTH, DEF_L_WIDTH);
    localparam int DEF_WEN_WIDTH   = wen_width(DEF_Q_WIDTH, DEF_L_WIDTH);
    localparam int DEF_A_DUR_WIDTH = a_dur_width(DEF_L_WIDTH);
    localparam int DEF_A_WIDTH     = a_width(DEF_L_WIDTH);

    // One BRAM word per state, WEN_WIDTH bytes wide: address = S * WEN_WIDTH.
    // Callers truncate the result to their own address width.
    function automatic logic [63:0] bram_addr(input logic [63:0] s, input int wen_w);
        return s * 64'(wen_w);
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SCAN    = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/q_table_reader_if.sv
// ----------------------------------------------------------------------------
// q_table_reader_if
// Bundles the request/result handshake and the BRAM read bus of the Q-table
// reader.
//   Request : start, S, A_in                      (master -> slave)
//   BRAM    : rd_addr (slave -> master), D_road0..3 (master -> slave)
//   Result  : busy, done, Q_max, A_max, Q_sel     (slave -> master)
// Handshake: start is a level request, accepted on any rising edge where the
// slave is idle (busy=0). busy stays high from the accept edge until the edge
// after the single-cycle done pulse; results are valid while done=1 and hold
// until the next done. start is ignored while busy=1.
// Modports: master = requester/BRAM side, slave = q_table_reader.
// ----------------------------------------------------------------------------
interface q_table_reader_if #(
    parameter int L_WIDTH    = 4,
    parameter int Q_WIDTH    = 16,
    parameter int ADDR_WIDTH = 32
);
    import intellight_pkg::*;

    localparam int S_WIDTH = s_width(L_WIDTH);
    localparam int A_WIDTH = a_width(L_WIDTH);
    localparam int D_WIDTH = d_width(Q_WIDTH, L_WIDTH);

    logic                  start;
    logic [S_WIDTH-1:0]    S;
    logic [A_WIDTH-1:0]    A_in;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [D_WIDTH-1:0]    D_road0;
    logic [D_WIDTH-1:0]    D_road1;
    logic [D_WIDTH-1:0]    D_road2;
    logic [D_WIDTH-1:0]    D_road3;
    logic                  busy;
    logic                  done;
    logic [Q_WIDTH-1:0]    Q_max;
    logic [A_WIDTH-1:0]    A_max;
    logic [Q_WIDTH-1:0]    Q_sel;

    modport master (
        output start, S, A_in, D_road0, D_road1, D_road2, D_road3,
        input  rd_addr, busy, done, Q_max, A_max, Q_sel
    );

    modport slave (
        input  start, S, A_in, D_road0, D_road1, D_road2, D_road3,
        output rd_addr, busy, done, Q_max, A_max, Q_sel
    );

endinterface

// File: rtl/q_argmax_road.sv
// ----------------------------------------------------------------------------
// q_argmax_road
// Combinational signed max / argmax over the N_LEVEL Q-values of one road.
// Ties resolve to the lowest duration index.
//   d_word  in  Q_WIDTH*N_LEVEL  packed values, duration d at [d*Q_WIDTH +: Q_WIDTH]
//   max_val out Q_WIDTH          largest value (signed)
//   max_dur out DUR_WIDTH        duration index of max_val
// ----------------------------------------------------------------------------
module q_argmax_road #(
    parameter int Q_WIDTH   = 16,
    parameter int N_LEVEL   = 4,
    parameter int DUR_WIDTH = 2
) (
    input  logic        [Q_WIDTH*N_LEVEL-1:0] d_word,
    output logic signed [Q_WIDTH-1:0]         max_val,
    output logic        [DUR_WIDTH-1:0]       max_dur
);

    always_comb begin
        max_val = $signed(d_word[Q_WIDTH-1:0]);
        max_dur = '0;
        // Strict '>' keeps the earlier index on ties.
        for (int i = 1; i < N_LEVEL; i++) begin
            if ($signed(d_word[i*Q_WIDTH +: Q_WIDTH]) > max_val) begin
                max_val = $signed(d_word[i*Q_WIDTH +: Q_WIDTH]);
                max_dur = DUR_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/q_table_reader.sv
// ----------------------------------------------------------------------------
// q_table_reader
// Read side of the Q-table BRAMs. On an accepted start it addresses all four
// road BRAMs at state S, waits BRAM_LAT cycles, captures the four words, then
// scans one road per cycle to find the signed maximum Q-value, its action
// {road, dur}, and the Q-value of the requested action A_in.
//   clk        in  rising-edge clock
//   rst        in  synchronous active-low reset
//   bus        q_table_reader_if.slave (start/S/A_in, rd_addr/D_road*,
//              busy/done/Q_max/A_max/Q_sel)
//   dbg_state  out current FSM state
// ----------------------------------------------------------------------------
module q_table_reader
    import intellight_pkg::*;
#(
    parameter int L_WIDTH    = 4,
    parameter int Q_WIDTH    = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int BRAM_LAT   = 2
) (
    input  logic              clk,
    input  logic              rst,
    q_table_reader_if.slave   bus,
    output state_e            dbg_state
);

    localparam int N_LEVEL     = n_level(L_WIDTH);
    localparam int D_WIDTH     = d_width(Q_WIDTH, L_WIDTH);
    localparam int WEN_WIDTH   = wen_width(Q_WIDTH, L_WIDTH);
    localparam int A_DUR_WIDTH = a_dur_width(L_WIDTH);
    localparam int A_WIDTH     = a_width(L_WIDTH);
    localparam int CNT_W       = (BRAM_LAT > 1) ? $clog2(BRAM_LAT) : 1;

    state_e                     state_q,   state_d;
    logic [CNT_W-1:0]           cnt_q,     cnt_d;
    logic [1:0]                 road_q,    road_d;
    logic [A_WIDTH-1:0]         a_in_q,    a_in_d;
    logic [ADDR_WIDTH-1:0]      rd_addr_q, rd_addr_d;
    logic [D_WIDTH-1:0]         cap_q [N_ROAD];
    logic [D_WIDTH-1:0]         cap_d [N_ROAD];
    logic signed [Q_WIDTH-1:0]  best_q,    best_d;
    logic [A_WIDTH-1:0]         best_a_q,  best_a_d;
    logic [Q_WIDTH-1:0]         q_max_q,   q_max_d;
    logic [A_WIDTH-1:0]         a_max_q,   a_max_d;
    logic [Q_WIDTH-1:0]         q_sel_q,   q_sel_d;

    // ------------------------------------------------------------------
    // Per-road reduction: one argmax instance, fed by the scan road counter
    // ------------------------------------------------------------------
    logic [D_WIDTH-1:0]         road_word;
    logic signed [Q_WIDTH-1:0]  road_max;
    logic [A_DUR_WIDTH-1:0]     road_dur;

    assign road_word = cap_q[road_q];

    q_argmax_road #(
        .Q_WIDTH   (Q_WIDTH),
        .N_LEVEL   (N_LEVEL),
        .DUR_WIDTH (A_DUR_WIDTH)
    ) u_argmax (
        .d_word  (road_word),
        .max_val (road_max),
        .max_dur (road_dur)
    );

    // Fold the road's local max into the running best. Road 0 seeds the
    // best outright; later roads replace it only when strictly greater, so
    // ties keep the lowest road.
    logic signed [Q_WIDTH-1:0]  fold_val;
    logic [A_WIDTH-1:0]         fold_a;

    always_comb begin
        fold_val = best_q;
        fold_a   = best_a_q;
        if (road_q == 2'd0 || road_max > best_q) begin
            fold_val = road_max;
            fold_a   = {road_q, road_dur};
        end
    end

    // Q-value of the requested action, read from the captured words.
    logic [A_ROAD_WIDTH-1:0]    sel_road;
    logic [A_DUR_WIDTH-1:0]     sel_dur;
    logic [D_WIDTH-1:0]         sel_word;
    logic [Q_WIDTH-1:0]         sel_val;

    always_comb begin
        sel_road = a_in_q[A_WIDTH-1 -: A_ROAD_WIDTH];
        sel_dur  = a_in_q[A_DUR_WIDTH-1:0];
        sel_word = cap_q[sel_road];
        sel_val  = sel_word[int'(sel_dur)*Q_WIDTH +: Q_WIDTH];
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        road_d  = road_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                // BRAM_LAT cycles in WAIT: the data read at rd_addr is on
                // D_road* during the following CAPTURE cycle.
                if (cnt_q == CNT_W'(BRAM_LAT - 1)) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CAPTURE: begin
                state_d = ST_SCAN;
                road_d  = 2'd0;
            end
            ST_SCAN: begin
                road_d = road_q + 2'd1;
                if (road_q == 2'd3) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next state
    // ------------------------------------------------------------------
    always_comb begin
        a_in_d    = a_in_q;
        rd_addr_d = rd_addr_q;
        best_d    = best_q;
        best_a_d  = best_a_q;
        q_max_d   = q_max_q;
        a_max_d   = a_max_q;
        q_sel_d   = q_sel_q;
        for (int i = 0; i < N_ROAD; i++) begin
            cap_d[i] = cap_q[i];
        end
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_in_d    = bus.A_in;
                    rd_addr_d = ADDR_WIDTH'(bram_addr(64'(bus.S), WEN_WIDTH));
                end
            end
            ST_CAPTURE: begin
                cap_d[0] = bus.D_road0;
                cap_d[1] = bus.D_road1;
                cap_d[2] = bus.D_road2;
                cap_d[3] = bus.D_road3;
            end
            ST_SCAN: begin
                best_d   = fold_val;
                best_a_d = fold_a;
                // Results are published together on the edge entering DONE.
                if (road_q == 2'd3) begin
                    q_max_d = fold_val;
                    a_max_d = fold_a;
                    q_sel_d = sel_val;
                end
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            road_q    <= '0;
            a_in_q    <= '0;
            rd_addr_q <= '0;
            best_q    <= '0;
            best_a_q  <= '0;
            q_max_q   <= '0;
            a_max_q   <= '0;
            q_sel_q   <= '0;
            for (int i = 0; i < N_ROAD; i++) begin
                cap_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            road_q    <= road_d;
            a_in_q    <= a_in_d;
            rd_addr_q <= rd_addr_d;
            best_q    <= best_d;
            best_a_q  <= best_a_d;
            q_max_q   <= q_max_d;
            a_max_q   <= a_max_d;
            q_sel_q   <= q_sel_d;
            for (int i = 0; i < N_ROAD; i++) begin
                cap_q[i] <= cap_d[i];
            end
        end
    end

    assign bus.rd_addr = rd_addr_q;
    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.done    = (state_q == ST_DONE);
    assign bus.Q_max   = q_max_q;
    assign bus.A_max   = a_max_q;
    assign bus.Q_sel   = q_sel_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_q_table_reader.sv
// ----------------------------------------------------------------------------
// tb_q_table_reader
// Directed bench for q_table_reader (default parameters). The driver issues
// requests, models the BRAM read latency (D_road* carries junk except in the
// one cycle the reader must capture), and checks address/timing. A monitor
// pops the expected {Q_max, A_max, Q_sel} whenever done is high.
// ----------------------------------------------------------------------------
module tb_q_table_reader;
    import intellight_pkg::*;

    localparam int L_WIDTH    = 4;
    localparam int Q_WIDTH    = 16;
    localparam int ADDR_WIDTH = 32;
    localparam int BRAM_LAT   = 2;
    localparam int LAT_DONE   = BRAM_LAT + 5;
    localparam logic [63:0] JUNK = 64'h5A5A_5A5A_5A5A_5A5A;

    localparam int MODE_NORMAL = 0;
    localparam int MODE_POKE   = 1;
    localparam int MODE_RESET  = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    q_table_reader_if #(
        .L_WIDTH    (L_WIDTH),
        .Q_WIDTH    (Q_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) bus ();

    state_e dbg_state;

    q_table_reader #(
        .L_WIDTH    (L_WIDTH),
        .Q_WIDTH    (Q_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BRAM_LAT   (BRAM_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [35:0] exp_q[$];   // {Q_max, A_max, Q_sel}

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [35:0] e;
        if (rst && bus.done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                e = exp_q.pop_front();
                check("q_max", 64'(bus.Q_max), 64'(e[35:20]));
                check("a_max", 64'(bus.A_max), 64'(e[19:16]));
                check("q_sel", 64'(bus.Q_sel), 64'(e[15:0]));
            end
        end
    end

    // ---------------- driver ----------------
    task automatic set_data(input logic [63:0] d0, d1, d2, d3);
        bus.D_road0 = d0;
        bus.D_road1 = d1;
        bus.D_road2 = d2;
        bus.D_road3 = d3;
    endtask

    task automatic run_req(input logic [7:0] s, input logic [3:0] a,
                           input logic [63:0] d0, d1, d2, d3,
                           input logic [35:0] exp, input int mode);
        int w;
        int n;
        int done_at;
        logic [63:0] exp_addr;
        exp_addr = 64'(s) << 3;
        w = 0;
        while (bus.busy && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (bus.busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=1 expected busy=0 within 20 cycles");
        end
        @(negedge clk);
        bus.S     = s;
        bus.A_in  = a;
        bus.start = 1'b1;
        set_data(JUNK, JUNK, JUNK, JUNK);
        if (mode != MODE_RESET) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("busy_after_accept", 64'(bus.busy), 64'd1);
        check("rd_addr", 64'(bus.rd_addr), exp_addr);
        done_at = -1;
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            n++;
            #1;
            if (n == BRAM_LAT) set_data(d0, d1, d2, d3);
            if (n == BRAM_LAT + 1) set_data(JUNK, JUNK, JUNK, JUNK);
            if (mode == MODE_POKE) bus.start = (n == 1 || n == LAT_DONE);
            if (mode == MODE_RESET && n == 5) rst = 1'b0;
            if (mode == MODE_RESET && n == 6) begin
                rst = 1'b1;
                check("rst_busy",    64'(bus.busy),    64'd0);
                check("rst_done",    64'(bus.done),    64'd0);
                check("rst_rd_addr", 64'(bus.rd_addr), 64'd0);
                check("rst_q_max",   64'(bus.Q_max),   64'd0);
                check("rst_a_max",   64'(bus.A_max),   64'd0);
                check("rst_q_sel",   64'(bus.Q_sel),   64'd0);
                check("rst_state",   64'(dbg_state),   64'(ST_IDLE));
            end
            if (bus.done && done_at < 0) done_at = n;
            if (mode != MODE_RESET && n == LAT_DONE + 1) begin
                check("done_one_cycle", 64'(bus.done), 64'd0);
                check("busy_drop",      64'(bus.busy), 64'd0);
            end
            if (mode != MODE_RESET && n == LAT_DONE + 3) begin
                check("busy_stay_idle", 64'(bus.busy),    64'd0);
                check("rd_addr_hold",   64'(bus.rd_addr), exp_addr);
            end
        end
        if (mode == MODE_RESET) begin
            check("no_done_after_reset", 64'(done_at < 0), 64'd1);
        end else begin
            if (done_at < 0) begin
                checks++;
                errors++;
                $display("FAIL done_timeout: got no done expected done at cycle %0d", LAT_DONE);
            end else begin
                check("done_latency", 64'(done_at), 64'(LAT_DONE));
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.start = 1'b0;
        bus.S     = '0;
        bus.A_in  = '0;
        set_data(JUNK, JUNK, JUNK, JUNK);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",    64'(bus.busy),    64'd0);
        check("reset_done",    64'(bus.done),    64'd0);
        check("reset_rd_addr", 64'(bus.rd_addr), 64'd0);
        check("reset_q_max",   64'(bus.Q_max),   64'd0);
        check("reset_a_max",   64'(bus.A_max),   64'd0);
        check("reset_q_sel",   64'(bus.Q_sel),   64'd0);
        check("reset_state",   64'(dbg_state),   64'(ST_IDLE));
        rst = 1'b1;

        // Address map + road2 max; A_in = road2 dur0.
        run_req(8'h05, 4'h8, 64'h0, 64'h0, 64'h0010_7FFF_0003_0001, 64'h0,
                {16'h7FFF, 4'hA, 16'h0001}, MODE_NORMAL);
        // All zero.
        run_req(8'h00, 4'h3, 64'h0, 64'h0, 64'h0, 64'h0,
                {16'h0000, 4'h0, 16'h0000}, MODE_NORMAL);
        // All 0x8000 except road3 dur3 = -1.
        run_req(8'hFF, 4'hF, {4{16'h8000}}, {4{16'h8000}}, {4{16'h8000}},
                64'hFFFF_8000_8000_8000,
                {16'hFFFF, 4'hF, 16'hFFFF}, MODE_NORMAL);
        // All 0x8000: seed wins.
        run_req(8'h80, 4'h5, {4{16'h8000}}, {4{16'h8000}}, {4{16'h8000}}, {4{16'h8000}},
                {16'h8000, 4'h0, 16'h8000}, MODE_NORMAL);
        // Tie between road1 dur0 and road3 dur1.
        run_req(8'h13, 4'hD, 64'h0, 64'h0000_0000_0000_0100, 64'h0, 64'h0000_0000_0100_0000,
                {16'h0100, 4'h4, 16'h0100}, MODE_NORMAL);
        // Select path, with start poked in WAIT and DONE.
        run_req(8'h21, 4'h6, 64'h0, 64'h0000_1234_0000_0000, 64'h0, 64'h0,
                {16'h1234, 4'h6, 16'h1234}, MODE_POKE);
        // Reset mid-SCAN: request dropped.
        run_req(8'h44, 4'h0, 64'h0000_0000_0000_7000, 64'h0, 64'h0, 64'h0,
                {16'h7000, 4'h0, 16'h7000}, MODE_RESET);
        // Fresh request after the reset; signed compare with negatives.
        run_req(8'h3C, 4'h1, 64'hFFFF_0002_8000_0001, 64'h0002_0000_0000_0000,
                64'h0, {4{16'hFFFF}},
                {16'h0002, 4'h2, 16'h8000}, MODE_NORMAL);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
